// File: rtl/riscv_pipe_pkg.sv
// Shared types for the pipeline sequencer: shadow slot record, EX operand selects, FSM states.
// Latency: none (types and pure helper functions only).
// Backpressure: none.
package riscv_pipe_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_access;
    } slot_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } seq_state_e;

    function automatic slot_t make_slot(input logic       valid,
                                        input logic [4:0] rd,
                                        input logic       reg_write,
                                        input logic       mem_read,
                                        input logic       mem_write);
        slot_t s;
        s.valid      = valid;
        s.rd         = rd;
        s.reg_write  = reg_write;
        s.mem_read   = mem_read;
        s.mem_access = mem_read | mem_write;
        return s;
    endfunction

    // The younger producer (EX) holds the newer value, so it wins over MEM.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return FWD_EXMEM;
        end
        if (mem_hit) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Compares the ID instruction's source operands against one in-flight shadow slot.
// Latency: purely combinational.
// Backpressure: none; the raw output feeds the sequencer's stall decision.
module hazard_cmp (
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       slot_valid,
    input  logic [4:0] slot_rd,
    input  logic       slot_reg_write,
    output logic       rs1_hit,
    output logic       rs2_hit,
    output logic       raw
);

    logic producer;

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    assign producer = id_valid & slot_valid & slot_reg_write & (slot_rd != 5'd0);
    assign rs1_hit  = producer & id_uses_rs1 & (id_rs1 == slot_rd);
    assign rs2_hit  = producer & id_uses_rs2 & (id_rs2 == slot_rd);
    assign raw      = rs1_hit | rs2_hit;

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/freeze/forward control for a 5-stage in-order pipeline; FORWARDING_EN enables EX operand forwarding.
// Latency: stage enables and dmem_req are combinational from shadow state and inputs; fwd_a/fwd_b register on advance.
// Backpressure: a data access without dmem_ack freezes every stage; RAW hazards insert an ID/EX bubble.
module pipeline_sequencer
    import riscv_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       id_valid,
    input  logic [4:0] id_rd,
    input  logic       id_reg_write,
    input  logic       id_mem_read,
    input  logic       id_mem_write,
    input  logic       dmem_ack,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_bubble,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       dmem_req,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

`ifdef FORWARDING_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    seq_state_e state_q, state_d;
    slot_t      slot_q [3];
    slot_t      slot_d [3];
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic       rs1_hit [2];
    logic       rs2_hit [2];
    logic       raw     [2];
    logic       hazard;
    logic       freeze;
    logic       req;

    for (genvar g = 0; g < 2; g++) begin : g_cmp
        hazard_cmp u_cmp (
            .id_valid       (id_valid),
            .id_rs1         (id_rs1),
            .id_rs2         (id_rs2),
            .id_uses_rs1    (id_uses_rs1),
            .id_uses_rs2    (id_uses_rs2),
            .slot_valid     (slot_q[g].valid),
            .slot_rd        (slot_q[g].rd),
            .slot_reg_write (slot_q[g].reg_write),
            .rs1_hit        (rs1_hit[g]),
            .rs2_hit        (rs2_hit[g]),
            .raw            (raw[g])
        );
    end

    // Write-before-read register file: a WB producer is never a hazard.
`ifdef FORWARDING_EN
    assign hazard = raw[SLOT_EX] & slot_q[SLOT_EX].mem_read;
`else
    assign hazard = raw[SLOT_EX] | raw[SLOT_MEM];
`endif

    always_comb begin
        req     = slot_q[SLOT_MEM].valid & slot_q[SLOT_MEM].mem_access;
        state_d = state_q;
        freeze  = 1'b0;
        if (state_q == RUN) begin
            if (req && !dmem_ack) begin
                state_d = MEM_WAIT;
                freeze  = 1'b1;
            end
        end else begin
            req = 1'b1;
            if (dmem_ack) begin
                state_d = RUN;
            end else begin
                freeze = 1'b1;
            end
        end

        slot_d      = slot_q;
        fwd_a_d     = fwd_a_q;
        fwd_b_d     = fwd_b_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        idex_bubble = 1'b0;

        // Freeze outranks the hazard; the hazard is simply re-evaluated once unfrozen.
        if (!freeze) begin
            idex_en          = 1'b1;
            exmem_en         = 1'b1;
            memwb_en         = 1'b1;
            slot_d[SLOT_WB]  = slot_q[SLOT_MEM];
            slot_d[SLOT_MEM] = slot_q[SLOT_EX];
            if (hazard) begin
                idex_bubble     = 1'b1;
                slot_d[SLOT_EX] = '0;
                fwd_a_d         = FWD_RF;
                fwd_b_d         = FWD_RF;
            end else begin
                pc_en           = 1'b1;
                ifid_en         = 1'b1;
                slot_d[SLOT_EX] = make_slot(id_valid, id_rd, id_reg_write,
                                            id_mem_read, id_mem_write);
                fwd_a_d = FWD_ON ? fwd_sel(rs1_hit[SLOT_EX], rs1_hit[SLOT_MEM]) : FWD_RF;
                fwd_b_d = FWD_ON ? fwd_sel(rs2_hit[SLOT_EX], rs2_hit[SLOT_MEM]) : FWD_RF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            slot_q[SLOT_EX]  <= '0;
            slot_q[SLOT_MEM] <= '0;
            slot_q[SLOT_WB]  <= '0;
            fwd_a_q          <= FWD_RF;
            fwd_b_q          <= FWD_RF;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign dmem_req = req;
    assign fwd_a    = fwd_a_q;
    assign fwd_b    = fwd_b_q;

endmodule
